// File: rtl/snake_io_support.sv
// snake_io_support: VGA clock divider, deglitched PS/2 receiver and 16-bit LFSR for the snake game.
// Build option PS2_BREAK_FILTER_EN swallows F0 break sequences and E0 prefixes.
module snake_io_support #(
  parameter int DIV = 4,
  parameter int FILTER_LEN = 8,
  parameter int IDLE_TIMEOUT = 50000,
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic        clk_div_out,
  output logic [7:0]  key_code,
  output logic        key_valid,
  output logic [15:0] random_num
);
  localparam int CW = DIV > 2 ? $clog2(DIV / 2) : 1;
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [15:0] SEED_OK = SEED == 16'h0000 ? 16'h0001 : SEED;
  localparam logic [1:0] IDLE = 2'd0, DATA = 2'd1, PARITY = 2'd2, STOP = 2'd3;
  logic [CW-1:0] div_cnt;
  logic [1:0] clk_sync, data_sync;
  logic [FW-1:0] flt_cnt;
  logic filt, fall;
  logic [1:0] state;
  logic [2:0] bit_cnt;
  logic [7:0] sh;
  logic par;
  logic [TW-1:0] tcnt;
  logic s_clk, s_data, good;
  assign s_clk = clk_sync[1];
  assign s_data = data_sync[1];
  assign good = s_data & (^sh ^ par);
  always_ff @(posedge clk)
    if (rst) begin
      div_cnt <= '0;
      clk_div_out <= 1'b0;
    end else if (div_cnt == CW'(DIV / 2 - 1)) begin
      div_cnt <= '0;
      clk_div_out <= ~clk_div_out;
    end else
      div_cnt <= div_cnt + CW'(1);
  // The filtered clock only moves after FILTER_LEN consecutive samples disagree with it.
  always_ff @(posedge clk)
    if (rst) begin
      clk_sync <= 2'b11;
      data_sync <= 2'b11;
      filt <= 1'b1;
      flt_cnt <= '0;
      fall <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
      fall <= 1'b0;
      if (s_clk == filt)
        flt_cnt <= '0;
      else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
        filt <= s_clk;
        flt_cnt <= '0;
        fall <= filt;
      end else
        flt_cnt <= flt_cnt + FW'(1);
    end
`ifdef PS2_BREAK_FILTER_EN
  logic brk;
`endif
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      bit_cnt <= '0;
      sh <= '0;
      par <= 1'b0;
      tcnt <= '0;
      key_code <= 8'h00;
      key_valid <= 1'b0;
`ifdef PS2_BREAK_FILTER_EN
      brk <= 1'b0;
`endif
    end else begin
      key_valid <= 1'b0;
      tcnt <= (state == IDLE || fall) ? '0 : tcnt + TW'(1);
      if (state != IDLE && !fall && tcnt == TW'(IDLE_TIMEOUT - 1))
        state <= IDLE;
      else if (fall)
        case (state)
          IDLE: begin
            state <= s_data ? IDLE : DATA;
            bit_cnt <= '0;
          end
          DATA: begin
            sh <= {s_data, sh[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            state <= bit_cnt == 3'd7 ? PARITY : DATA;
          end
          PARITY: begin
            par <= s_data;
            state <= STOP;
          end
          default: begin
            state <= IDLE;
`ifdef PS2_BREAK_FILTER_EN
            if (good) begin
              if (brk)
                brk <= 1'b0;
              else if (sh == 8'hF0)
                brk <= 1'b1;
              else if (sh != 8'hE0) begin
                key_code <= sh;
                key_valid <= 1'b1;
              end
            end
`else
            if (good) begin
              key_code <= sh;
              key_valid <= 1'b1;
            end
`endif
          end
        endcase
    end
  always_ff @(posedge clk)
    random_num <= rst ? SEED_OK : {random_num[14:0], random_num[15] ^ random_num[13] ^ random_num[12] ^ random_num[10]};
endmodule

// File: tb/tb_snake_io_support.sv
// tb_snake_io_support: randomized self-checking bench for snake_io_support against a byte-level model.
module tb_snake_io_support;
  localparam int DIV = 4;
  localparam int FILTER_LEN = 8;
  localparam int IDLE_TIMEOUT = 2000;
  localparam int H = 32;
  logic clk = 1'b0, rst = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1;
  logic clk_div_out, key_valid;
  logic [7:0] key_code;
  logic [15:0] random_num;
  int checks = 0, errors = 0;
  logic [7:0] obs[$], exp_q[$];
  logic [7:0] last_code = 8'h00;
  bit brk_m = 1'b0;
  snake_io_support #(.DIV(DIV), .FILTER_LEN(FILTER_LEN), .IDLE_TIMEOUT(IDLE_TIMEOUT), .SEED(16'hACE1)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .clk_div_out(clk_div_out), .key_code(key_code), .key_valid(key_valid), .random_num(random_num)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (key_valid) obs.push_back(key_code);
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    cycles(3);
    rst = 1'b0;
    last_code = 8'h00;
    brk_m = 1'b0;
    obs.delete();
    exp_q.delete();
  endtask
  task automatic send_bit(input logic b, input bit g);
    ps2_data = b;
    cycles(H / 4);
    if (g) begin
      ps2_clk = 1'b0;
      cycles(3);
      ps2_clk = 1'b1;
    end
    cycles(H / 4);
    ps2_clk = 1'b0;
    cycles(H / 2);
    if (g) begin
      ps2_clk = 1'b1;
      cycles(3);
      ps2_clk = 1'b0;
    end
    cycles(H / 2);
    ps2_clk = 1'b1;
    cycles(H / 2);
  endtask
  task automatic model_good(input logic [7:0] b);
`ifdef PS2_BREAK_FILTER_EN
    if (brk_m) brk_m = 1'b0;
    else if (b == 8'hF0) brk_m = 1'b1;
    else if (b != 8'hE0) begin
      exp_q.push_back(b);
      last_code = b;
    end
`else
    exp_q.push_back(b);
    last_code = b;
`endif
  endtask
  task automatic send_frame(input logic [7:0] b, input bit bad, input bit g);
    send_bit(1'b0, g);
    for (int i = 0; i < 8; i++) send_bit(b[i], g);
    send_bit(~^b ^ bad, g);
    send_bit(1'b1, g);
    if (!bad) model_good(b);
  endtask
  task automatic check_rx(input string name);
    bit ok;
    cycles(10);
    ok = obs.size() == exp_q.size();
    if (ok) foreach (obs[i]) if (obs[i] !== exp_q[i]) ok = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s pulses: got %0d bytes (last %h), expected %0d bytes (last %h)", name,
               obs.size(), obs.size() ? obs[$] : 8'h00, exp_q.size(), exp_q.size() ? exp_q[$] : 8'h00);
    end
    checks++;
    if (key_code !== last_code) begin
      errors++;
      $display("FAIL %s key_code: got %h expected %h", name, key_code, last_code);
    end
    obs.delete();
    exp_q.delete();
  endtask
  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1;
    cycles(3);
    checks++;
    if ({clk_div_out, key_code, key_valid, random_num} !== {1'b0, 8'h00, 1'b0, 16'hACE1}) begin
      errors++;
      $display("FAIL reset: got div=%b code=%h valid=%b rnd=%h expected 0 00 0 ace1",
               clk_div_out, key_code, key_valid, random_num);
    end
    rst = 1'b0;
  endtask
  task automatic test_div;
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      checks++;
      if (clk_div_out !== 1'((k / (DIV / 2)) % 2)) begin
        errors++;
        $display("FAIL div edge %0d: got %b expected %b", k, clk_div_out, (k / (DIV / 2)) % 2);
      end
    end
  endtask
  task automatic test_lfsr;
    logic [15:0] m;
    int mism = 0, zeros = 0, first_ret = 0;
    do_reset();
    m = 16'hACE1;
    checks++;
    if (random_num !== 16'hACE1) begin
      errors++;
      $display("FAIL lfsr_seed: got %h expected ace1", random_num);
    end
    for (int i = 1; i <= 65535; i++) begin
      @(negedge clk);
      m = {m[14:0], ^(m & 16'hB400)};
      if (i == 1) begin
        checks++;
        if (random_num !== 16'h59C3) begin
          errors++;
          $display("FAIL lfsr_step1: got %h expected 59c3", random_num);
        end
      end
      if (random_num !== m) mism++;
      if (random_num == 16'h0000) zeros++;
      if (random_num == 16'hACE1 && first_ret == 0) first_ret = i;
    end
    checks++;
    if (mism != 0) begin
      errors++;
      $display("FAIL lfsr_track: got %0d mismatching cycles expected 0", mism);
    end
    checks++;
    if (zeros != 0) begin
      errors++;
      $display("FAIL lfsr_zero: got %0d zero states expected 0", zeros);
    end
    checks++;
    if (first_ret != 65535) begin
      errors++;
      $display("FAIL lfsr_period: got %0d expected 65535", first_ret);
    end
  endtask
  task automatic test_frame;
    do_reset();
    send_frame(8'h1D, 1'b0, 1'b0);
    check_rx("frame_1d");
  endtask
  task automatic test_parity;
    send_frame(8'h1D, 1'b1, 1'b0);
    check_rx("bad_parity");
    send_frame(8'h1C, 1'b0, 1'b0);
    check_rx("good_1c");
  endtask
  task automatic test_timeout;
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    cycles(IDLE_TIMEOUT + 100);
    send_frame(8'h23, 1'b0, 1'b0);
    check_rx("timeout_23");
  endtask
  task automatic test_rst_mid_frame;
    send_frame(8'hF0, 1'b0, 1'b0);
    check_rx("pre_rst_f0");
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b0);
    do_reset();
    send_frame(8'h23, 1'b0, 1'b0);
    check_rx("rst_mid_23");
  endtask
  task automatic test_break;
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h1D, 1'b0, 1'b1);
    check_rx("break_f0_1d");
    send_frame(8'hE0, 1'b0, 1'b1);
    send_frame(8'h75, 1'b0, 1'b1);
    check_rx("ext_e0_75");
  endtask
  task automatic test_random;
    logic [7:0] b;
    for (int n = 0; n < 7; n++) begin
      b = $urandom_range(0, 3) == 0 ? ($urandom_range(0, 1) ? 8'hF0 : 8'hE0) : 8'($urandom);
      send_frame(b, $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)));
      check_rx("random");
    end
  endtask
  initial begin
    test_reset();
    test_div();
    test_frame();
    test_parity();
    test_timeout();
    test_rst_mid_frame();
    test_break();
    test_random();
    test_lfsr();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
